// File: rtl/mul_iter.sv
// Iterative RV32M/RV64M multiplier: retires BPC multiplier bits per cycle on operand magnitudes,
// then applies the sign in one fix-up cycle and presents the selected half of the product.
module mul_iter #(
    parameter int XLEN = 32,
    parameter int BPC  = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [1:0]      op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result
);

    localparam int STEPS = XLEN / BPC;
    localparam int CW    = $clog2(STEPS) + 1;
    localparam int W2    = 2 * XLEN;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_FIX  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    state_t          state_r;
    state_t          state_s;
    logic [1:0]      op_r;
    logic            neg_r;
    logic [W2-1:0]   mcand_r;
    logic [XLEN-1:0] mplier_r;
    logic [W2-1:0]   acc_r;
    logic [CW-1:0]   cnt_r;
    logic [XLEN-1:0] result_r;
    logic            in_ready_r;
    logic            out_valid_r;

    logic            a_neg_s;
    logic            b_neg_s;
    logic [XLEN-1:0] a_mag_s;
    logic [XLEN-1:0] b_mag_s;
    logic [W2-1:0]   pp_s;
    logic [W2-1:0]   product_s;
    logic [XLEN-1:0] slice_s;

    // Next-state logic; flush overrides every other transition.
    always_comb begin
        state_s = state_r;
        if (flush) begin
            state_s = ST_IDLE;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (in_valid) begin
                        state_s = ST_BUSY;
                    end else begin
                        state_s = ST_IDLE;
                    end
                end
                ST_BUSY: begin
                    if (cnt_r == CW'(STEPS - 1)) begin
                        state_s = ST_FIX;
                    end else begin
                        state_s = ST_BUSY;
                    end
                end
                ST_FIX: begin
                    state_s = ST_DONE;
                end
                ST_DONE: begin
                    if (out_ready) begin
                        state_s = ST_IDLE;
                    end else begin
                        state_s = ST_DONE;
                    end
                end
                default: begin
                    state_s = ST_IDLE;
                end
            endcase
        end
    end

    // Operand magnitudes; the most-negative value negates to itself, which is its correct unsigned magnitude.
    always_comb begin
        a_neg_s = 1'b0;
        b_neg_s = 1'b0;
        if ((op == 2'b01) || (op == 2'b10)) begin
            a_neg_s = a[XLEN-1];
        end else begin
            a_neg_s = 1'b0;
        end
        if (op == 2'b01) begin
            b_neg_s = b[XLEN-1];
        end else begin
            b_neg_s = 1'b0;
        end
        if (a_neg_s) begin
            a_mag_s = (~a) + {{(XLEN-1){1'b0}}, 1'b1};
        end else begin
            a_mag_s = a;
        end
        if (b_neg_s) begin
            b_mag_s = (~b) + {{(XLEN-1){1'b0}}, 1'b1};
        end else begin
            b_mag_s = b;
        end
    end

    // Partial product of the pre-shifted multiplicand and the current multiplier digit, plus the signed fix-up.
    always_comb begin
        pp_s = mcand_r * {{(W2-BPC){1'b0}}, mplier_r[BPC-1:0]};
        if (neg_r) begin
            product_s = (~acc_r) + {{(W2-1){1'b0}}, 1'b1};
        end else begin
            product_s = acc_r;
        end
        if (op_r == 2'b00) begin
            slice_s = product_s[XLEN-1:0];
        end else begin
            slice_s = product_s[W2-1:XLEN];
        end
    end

    // Control state and handshake outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
        end else begin
            state_r     <= state_s;
            in_ready_r  <= (state_s == ST_IDLE);
            out_valid_r <= (state_s == ST_DONE);
        end
    end

    // Datapath: operand capture, shift-add iteration and result register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_r     <= 2'b00;
            neg_r    <= 1'b0;
            mcand_r  <= {W2{1'b0}};
            mplier_r <= {XLEN{1'b0}};
            acc_r    <= {W2{1'b0}};
            cnt_r    <= {CW{1'b0}};
            result_r <= {XLEN{1'b0}};
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (state_s == ST_BUSY) begin
                        op_r     <= op;
                        neg_r    <= a_neg_s ^ b_neg_s;
                        mcand_r  <= {{XLEN{1'b0}}, a_mag_s};
                        mplier_r <= b_mag_s;
                        acc_r    <= {W2{1'b0}};
                        cnt_r    <= {CW{1'b0}};
                    end else begin
                        cnt_r    <= cnt_r;
                    end
                end
                ST_BUSY: begin
                    acc_r    <= acc_r + pp_s;
                    mcand_r  <= mcand_r << BPC;
                    mplier_r <= mplier_r >> BPC;
                    cnt_r    <= cnt_r + CW'(1);
                end
                ST_FIX: begin
                    if (state_s == ST_DONE) begin
                        result_r <= slice_s;
                    end else begin
                        result_r <= result_r;
                    end
                end
                default: begin
                    result_r <= result_r;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign result    = result_r;

endmodule

// File: tb/tb_mul_iter.sv
// Self-checking bench for mul_iter: three configurations (32/4, 32/1, 64/8) share one stimulus
// stream and are checked every cycle against an arithmetic model with handshake timing.
module tb_mul_iter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic [1:0]  op = 2'b00;
    logic [63:0] a64 = 64'd0;
    logic [63:0] b64 = 64'd0;

    logic [2:0]  ov;
    logic [2:0]  ir;
    logic [31:0] r0;
    logic [31:0] r1;
    logic [63:0] r2;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    mul_iter #(.XLEN(32), .BPC(4)) dut (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(ir[0]),
        .op(op), .a(a64[31:0]), .b(b64[31:0]), .out_valid(ov[0]), .out_ready(out_ready), .result(r0)
    );
    mul_iter #(.XLEN(32), .BPC(1)) dut_b1 (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(ir[1]),
        .op(op), .a(a64[31:0]), .b(b64[31:0]), .out_valid(ov[1]), .out_ready(out_ready), .result(r1)
    );
    mul_iter #(.XLEN(64), .BPC(8)) dut_w64 (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(ir[2]),
        .op(op), .a(a64), .b(b64), .out_valid(ov[2]), .out_ready(out_ready), .result(r2)
    );

    function automatic int xl(input int i);
        return (i == 2) ? 64 : 32;
    endfunction

    function automatic int steps(input int i);
        return (i == 0) ? 8 : ((i == 1) ? 32 : 8);
    endfunction

    function automatic logic [63:0] get_res(input int i);
        return (i == 0) ? {32'd0, r0} : ((i == 1) ? {32'd0, r1} : r2);
    endfunction

    // Reference: exact signed/unsigned product in wide arithmetic, then the op's slice.
    function automatic logic [63:0] mulref(input logic [1:0] o, input logic [63:0] x, input logic [63:0] y, input int w);
        logic signed [129:0] av;
        logic signed [129:0] bv;
        logic signed [129:0] p;
        logic [127:0]        pu;
        logic [63:0]         xm;
        logic [63:0]         ym;
        xm = (w == 32) ? {32'd0, x[31:0]} : x;
        ym = (w == 32) ? {32'd0, y[31:0]} : y;
        av = $signed({66'd0, xm});
        bv = $signed({66'd0, ym});
        if (((o == 2'b01) || (o == 2'b10)) && xm[w-1]) av = av - (130'sd1 <<< w);
        if ((o == 2'b01) && ym[w-1]) bv = bv - (130'sd1 <<< w);
        p  = av * bv;
        pu = p[127:0];
        if (o == 2'b00) return (w == 32) ? {32'd0, pu[31:0]} : pu[63:0];
        return (w == 32) ? {32'd0, pu[63:32]} : pu[127:64];
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model state: pending op, cycles since accept, expected result and the value result must hold.
    logic        pend [3];
    int          cyc  [3];
    logic [63:0] expv [3];
    logic [63:0] hold [3];

    always @(posedge clk or posedge rst) begin
        for (int i = 0; i < 3; i++) begin
            if (rst) begin
                pend[i] <= 1'b0;
                cyc[i]  <= 0;
                expv[i] <= 64'd0;
                hold[i] <= 64'd0;
            end else if (flush) begin
                pend[i] <= 1'b0;
            end else if (!pend[i]) begin
                if (in_valid) begin
                    pend[i] <= 1'b1;
                    cyc[i]  <= 0;
                    expv[i] <= mulref(op, a64, b64, xl(i));
                end
            end else if (cyc[i] < steps(i) + 1) begin
                cyc[i] <= cyc[i] + 1;
                if (cyc[i] + 1 == steps(i) + 1) hold[i] <= expv[i];
            end else if (out_ready) begin
                pend[i] <= 1'b0;
            end
        end
    end

    // Per-cycle comparison of every instance against the model.
    always @(negedge clk) begin
        if (!rst) begin
            for (int i = 0; i < 3; i++) begin
                chk($sformatf("out_valid[%0d]", i), {63'd0, ov[i]}, {63'd0, pend[i] && (cyc[i] == steps(i) + 1)});
                chk($sformatf("in_ready[%0d]", i), {63'd0, ir[i]}, {63'd0, !pend[i]});
                chk($sformatf("result[%0d]", i), get_res(i), hold[i]);
            end
        end
    end

    // Wait (bounded) until every instance has raised out_valid, then complete the handshake.
    task automatic drain(input string name);
        int k;
        k = 0;
        while ((ov !== 3'b111) && (k < 60)) begin
            @(posedge clk); #1;
            k++;
        end
        if (ov !== 3'b111) begin
            errors++;
            checks++;
            $display("FAIL %s_timeout: got out_valid=%b expected 111", name, ov);
        end
        @(negedge clk); out_ready = 1'b1;
        @(negedge clk); out_ready = 1'b0;
    endtask

    // Issue one op to all instances, check latency and (optionally) a hand-computed 32-bit result.
    task automatic run_op(input string name, input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                          input logic lit, input logic [31:0] exp32);
        int lat [3];
        for (int i = 0; i < 3; i++) lat[i] = -1;
        @(negedge clk);
        op = o; a64 = {{32{x[31]}}, x}; b64 = {{32{y[31]}}, y}; in_valid = 1'b1; out_ready = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0; a64 = ~a64; b64 = 64'd5; op = ~o;
        for (int k = 1; k <= 50; k++) begin
            @(posedge clk); #1;
            for (int i = 0; i < 3; i++) if (ov[i] && (lat[i] < 0)) lat[i] = k;
            if ((lat[0] >= 0) && (lat[1] >= 0) && (lat[2] >= 0)) break;
        end
        chk({name, "_lat32x4"}, 64'(lat[0]), 64'd9);
        chk({name, "_lat32x1"}, 64'(lat[1]), 64'd33);
        chk({name, "_lat64x8"}, 64'(lat[2]), 64'd9);
        if (lit) begin
            chk({name, "_res32x4"}, {32'd0, r0}, {32'd0, exp32});
            chk({name, "_res32x1"}, {32'd0, r1}, {32'd0, exp32});
        end
        @(negedge clk); out_ready = 1'b1;
        @(negedge clk); out_ready = 1'b0;
    endtask

    initial begin
        logic [31:0] ra;
        logic [31:0] rb;
        // Pin the model with hand-computed values.
        chk("model_mulhu", mulref(2'b11, 64'hFFFF_FFFF, 64'hFFFF_FFFF, 32), 64'h0000_0000_FFFF_FFFE);
        chk("model_mulh_min", mulref(2'b01, 64'h8000_0000, 64'h8000_0000, 32), 64'h0000_0000_4000_0000);
        chk("model_mulhsu", mulref(2'b10, 64'h0000_0002, 64'hFFFF_FFFF, 32), 64'h0000_0000_0000_0001);
        chk("model_mulh64", mulref(2'b01, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 64), 64'h4000_0000_0000_0000);
        chk("model_mulhu64", mulref(2'b11, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64), 64'hFFFF_FFFF_FFFF_FFFE);

        #12;
        chk("reset_out_valid", {61'd0, ov}, 64'd0);
        chk("reset_in_ready", {61'd0, ir}, 64'd7);
        chk("reset_result", get_res(0), 64'd0);
        @(negedge clk); rst = 1'b0;

        run_op("mulhu_ones", 2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 32'hFFFF_FFFE);
        run_op("mul_ones",   2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 32'h0000_0001);
        run_op("mulh_min",   2'b01, 32'h8000_0000, 32'h8000_0000, 1'b1, 32'h4000_0000);
        run_op("mulh_m1x3",  2'b01, 32'hFFFF_FFFF, 32'h0000_0003, 1'b1, 32'hFFFF_FFFF);
        run_op("mulhsu_m1",  2'b10, 32'hFFFF_FFFF, 32'h0000_0002, 1'b1, 32'hFFFF_FFFF);
        run_op("mulhsu_2",   2'b10, 32'h0000_0002, 32'hFFFF_FFFF, 1'b1, 32'h0000_0001);
        run_op("mulh_zero",  2'b01, 32'h0000_0000, 32'h8000_0000, 1'b1, 32'h0000_0000);
        run_op("mul_neg",    2'b00, 32'hFFFF_FFFD, 32'h0000_0007, 1'b1, 32'hFFFF_FFEB);

        // Flush at E4 discards the op; a new op accepted at E6 yields 42 nine edges later.
        @(negedge clk); op = 2'b00; a64 = 64'd1000; b64 = 64'd1000; in_valid = 1'b1;
        @(negedge clk); in_valid = 1'b0;
        repeat (3) @(negedge clk);
        flush = 1'b1;
        @(negedge clk); flush = 1'b0;
        @(negedge clk); op = 2'b00; a64 = 64'd7; b64 = 64'd6; in_valid = 1'b1;
        @(posedge clk); #1; in_valid = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        chk("flush_new_valid", {63'd0, ov[0]}, 64'd1);
        chk("flush_new_result", {32'd0, r0}, 64'd42);
        drain("flush");

        // Flush in IDLE with in_valid high: nothing accepted.
        @(negedge clk); flush = 1'b1; in_valid = 1'b1; op = 2'b00; a64 = 64'd3; b64 = 64'd3;
        @(negedge clk); flush = 1'b0; in_valid = 1'b0;
        chk("flush_idle_ready", {61'd0, ir}, 64'd7);
        repeat (12) @(negedge clk);
        chk("flush_idle_no_valid", {63'd0, ov[0]}, 64'd0);

        // Asynchronous reset mid-operation, between edges.
        @(negedge clk); op = 2'b11; a64 = 64'd9; b64 = 64'd9; in_valid = 1'b1;
        @(posedge clk); #1; in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("rst_mid_out_valid", {61'd0, ov}, 64'd0);
        chk("rst_mid_in_ready", {61'd0, ir}, 64'd7);
        chk("rst_mid_result", get_res(2), 64'd0);
        @(negedge clk); rst = 1'b0;

        // Random operands against the model on all three configurations.
        for (int n = 0; n < 6; n++) begin
            ra = $urandom;
            rb = $urandom;
            run_op("random", 2'(n % 4), ra, rb, 1'b1, mulref(2'(n % 4), {32'd0, ra}, {32'd0, rb}, 32) & 64'hFFFF_FFFF);
        end

        repeat (3) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
